ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX->MEM pipeline register of the 16-bit WISC pipeline; captures the ALU result
//  (ADD/SUB/XOR/RED/shift/PADDSB) plus MEM/WB control, and owns the N/Z/V flag register.
//  Flags are updated per opcode class as each instruction advances; decode reads them for branches.
//  Stall holds the stage. Flush inserts a bubble.
// PARAMETERS
//  DW   16  datapath width (ALU result, store data)
//  RW   4   register index width
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   synchronous active-high reset
//  stall          in   1   hold all stage state (MEM not ready)
//  flush          in   1   replace incoming instruction with bubble
//  ex_valid       in   1   EX holds a real instruction
//  ex_opcode      in   4   opcode of the EX instruction
//  ex_alu_result  in   DW  ALU output (RED result already sign-extended)
//  ex_ovfl        in   1   ALU signed-overflow indication
//  ex_store_data  in   DW  forwarded rt value for SW
//  ex_rd          in   RW  destination register
//  ex_reg_write   in   1   WB writes rd
//  ex_mem_read    in   1   LW
//  ex_mem_write   in   1   SW
//  ex_halt        in   1   HLT reached EX
//  mem_valid      out  1   MEM holds a real instruction
//  mem_alu_result out  DW  registered result / address
//  mem_store_data out  DW  registered store data
//  mem_rd         out  RW  registered destination
//  mem_reg_write  out  1   registered control
//  mem_mem_read   out  1   registered control
//  mem_mem_write  out  1   registered control
//  mem_halt       out  1   registered halt
//  flags          out  3   {N,Z,V} registered flag state
// BEHAVIOUR
//  - Reset: all mem_* outputs 0, flags 3'b000; reset dominates stall/flush.
//  - Latency: 1 cycle EX->MEM when advancing.
//  - Priority per cycle: rst > flush > stall > advance.
//  - Advance: every mem_* reg loads its ex_* input; mem_valid<=ex_valid.
//  - Flush: mem_valid, reg_write, mem_read, mem_write, halt <= 0; data regs don't-care (hold). Flags unchanged.
//    Flush while stalled also bubbles; flush wins.
//  - Stall (no flush): every register incl. flags holds.
//  - Flag update only on advance with ex_valid=1:
//      ADD 0000, SUB 0001: N<=result[15], Z<=(result==0), V<=ex_ovfl
//      XOR 0010, SLL 0100, SRA 0101, ROR 0110: Z only; N,V hold
//      RED 0011, PADDSB 0111, memory, branch, other: all flags hold
//  - Z is computed on the full DW-bit result. No saturation or width change in this stage.
//  - ex_valid=0 advances a bubble: control bits copied (expected 0), flags hold.
// CONFIGURATION
//  FLAG_BYPASS_EN defined: `flags` = next-flag value (combinational, same cycle as an updating
//    advance), so a branch in ID paired with ADD in EX resolves without a bubble.
//  Undefined: `flags` = registered value only. Hazard unit must stall the branch 1 cycle.
// STRUCTURE
//  - Shared package wisc_pkg: opcode localparams (OP_ADD..OP_PADDSB), flag bit indices FLAG_N/Z/V.
//  - One sub-module flag_logic: combinational {opcode, result, ovfl, cur_flags} -> next_flags
//    and update mask.
//  - This stage instantiates flag_logic and holds the registers.
// TESTING
//  1. ADD, result 0x0000, ovfl 0, advance -> next cycle mem_alu_result=0x0000, flags N=0 Z=1 V=0.
//  2. SUB, result 0x8000, ovfl 1 -> flags N=1 Z=0 V=1. Then XOR result 0x0005 -> N=1 Z=0 V=1.
//  3. flags=Z set, RED result 0x0000 -> flags unchanged, mem_alu_result=0x0000, mem_reg_write=1.
//  4. ADD result 0x1234 with stall=1 for 3 cycles -> outputs and flags hold prior values.
//     Release -> 0x1234 appears next cycle.
//  5. SW with flush=1 and stall=1 same cycle -> mem_valid=0, mem_mem_write=0, flags unchanged.
//  6. rst asserted mid-stream with ex_halt=1 -> next cycle all outputs 0, flags 000, mem_halt=0.
//     With FLAG_BYPASS_EN, ADD result 0 -> flags Z=1 same cycle.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC definitions: datapath widths, opcode encodings and the
// bit positions of the N/Z/V flags inside the 3-bit flag vector {N,Z,V}.
package wisc_pkg;

  localparam int WISC_DW = 16;
  localparam int WISC_RW = 4;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM bundle: the ex_* side is driven by EX (master), the mem_* side
// is driven by the pipeline register (slave).
interface ex_mem_stage_if
  import wisc_pkg::*;
#(
  parameter int DW = WISC_DW,
  parameter int RW = WISC_RW
);
  logic          ex_valid;
  logic [3:0]    ex_opcode;
  logic [DW-1:0] ex_alu_result;
  logic          ex_ovfl;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_halt;

  logic          mem_valid;
  logic [DW-1:0] mem_alu_result;
  logic [DW-1:0] mem_store_data;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_write;
  logic          mem_mem_read;
  logic          mem_mem_write;
  logic          mem_halt;

  modport master (
    output ex_valid, ex_opcode, ex_alu_result, ex_ovfl, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt,
    input  mem_valid, mem_alu_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, mem_halt
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_alu_result, ex_ovfl, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt,
    output mem_valid, mem_alu_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, mem_halt
  );
endinterface

// File: rtl/ex_mem_stage_flag_logic.sv
// flag_logic: decides which of N/Z/V an opcode class updates and forms the
// candidate next flag vector. Purely combinational; the caller decides
// whether the instruction actually advances.
module flag_logic
  import wisc_pkg::*;
#(
  parameter int DW = WISC_DW
) (
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] result,
  input  logic          ovfl,
  input  logic [2:0]    cur_flags,
  output logic [2:0]    next_flags,
  output logic [2:0]    update_mask
);

  logic [2:0] cand;

  // Select updated flags by opcode class and merge with the held flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    update_mask = 3'b000;
    cand        = 3'b000;
    cand[FLAG_N] = result[DW-1];
    cand[FLAG_Z] = (result == '0);
    cand[FLAG_V] = ovfl;
    case (opcode)
      OP_ADD, OP_SUB:                 update_mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: update_mask[FLAG_Z] = 1'b1;
      default:                        update_mask = 3'b000;
    endcase
    next_flags = (cand & update_mask) | (cur_flags & ~update_mask);
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register of the WISC pipeline, owner of
// the N/Z/V flag register. Priority per cycle: rst > flush > stall > advance.
// Build option FLAG_BYPASS_EN: `flags` shows the next-flag value in the same
// cycle as an updating advance, so a branch in ID need not wait a cycle.
module ex_mem_stage
  import wisc_pkg::*;
#(
  parameter int DW = WISC_DW,
  parameter int RW = WISC_RW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  ex_mem_stage_if.slave bus,
  output logic [2:0]   flags
);

  logic [2:0] flags_q;
  logic [2:0] flags_d;
  logic [2:0] fl_next;
  logic [2:0] fl_mask;
  logic       advance;

  flag_logic #(.DW(DW)) u_flag_logic (
    .opcode      (bus.ex_opcode),
    .result      (bus.ex_alu_result),
    .ovfl        (bus.ex_ovfl),
    .cur_flags   (flags_q),
    .next_flags  (fl_next),
    .update_mask (fl_mask)
  );

  assign advance = !flush && !stall;

  // Next flag state: cleared by reset, updated only by a real advancing instruction.
  always_comb begin
    flags_d = flags_q;
    if (rst)
      flags_d = 3'b000;
    else if (advance && bus.ex_valid && (fl_mask != 3'b000))
      flags_d = fl_next;
  end

  // Flag register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    flags_q <= flags_d;
  end

`ifdef FLAG_BYPASS_EN
  assign flags = flags_d;
`else
  assign flags = flags_q;
`endif

  // Pipeline register: reset clears, flush bubbles control, stall holds, else load.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset too because they are visible stage outputs.
      bus.mem_valid      <= 1'b0;
      bus.mem_alu_result <= '0;
      bus.mem_store_data <= '0;
      bus.mem_rd         <= '0;
      bus.mem_reg_write  <= 1'b0;
      bus.mem_mem_read   <= 1'b0;
      bus.mem_mem_write  <= 1'b0;
      bus.mem_halt       <= 1'b0;
    end else if (flush) begin
      bus.mem_valid     <= 1'b0;
      bus.mem_reg_write <= 1'b0;
      bus.mem_mem_read  <= 1'b0;
      bus.mem_mem_write <= 1'b0;
      bus.mem_halt      <= 1'b0;
    end else if (!stall) begin
      bus.mem_valid      <= bus.ex_valid;
      bus.mem_alu_result <= bus.ex_alu_result;
      bus.mem_store_data <= bus.ex_store_data;
      bus.mem_rd         <= bus.ex_rd;
      bus.mem_reg_write  <= bus.ex_reg_write;
      bus.mem_mem_read   <= bus.ex_mem_read;
      bus.mem_mem_write  <= bus.ex_mem_write;
      bus.mem_halt       <= bus.ex_halt;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with hand-computed expectations.
module tb_ex_mem_stage;
  import wisc_pkg::*;

  logic clk = 1'b0;
  logic rst, stall, flush;
  logic [2:0] flags;
  int checks = 0;
  int failures = 0;

  ex_mem_stage_if #(.DW(16), .RW(4)) bus ();

  ex_mem_stage #(.DW(16), .RW(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus.slave),
    .flags (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic rw, input logic mr, input logic mw,
                       input logic h);
    bus.ex_valid      = v;
    bus.ex_opcode     = op;
    bus.ex_alu_result = res;
    bus.ex_ovfl       = ov;
    bus.ex_store_data = res ^ 16'hA5A5;
    bus.ex_rd         = res[3:0] ^ 4'h7;
    bus.ex_reg_write  = rw;
    bus.ex_mem_read   = mr;
    bus.ex_mem_write  = mw;
    bus.ex_halt       = h;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    check("rst_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("rst_alu", {16'd0, bus.mem_alu_result}, 32'd0);
    check("rst_flags", {29'd0, flags}, 32'd0);

    // 1: ADD result 0 -> Z
    rst = 1'b0;
    drive(1'b1, OP_ADD, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FLAG_BYPASS_EN
    #1;
    check("byp_add_z", {29'd0, flags}, 32'h2);
`endif
    step();
    check("add0_alu", {16'd0, bus.mem_alu_result}, 32'h0000);
    check("add0_flags", {29'd0, flags}, 32'h2);
    check("add0_valid", {31'd0, bus.mem_valid}, 32'd1);
    check("add0_rd", {28'd0, bus.mem_rd}, 32'h7);
    check("add0_sd", {16'd0, bus.mem_store_data}, 32'hA5A5);

    // 2: SUB 0x8000 ovfl -> N,V; XOR 0x0005 -> Z only
    drive(1'b1, OP_SUB, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("sub_flags", {29'd0, flags}, 32'h5);
    check("sub_alu", {16'd0, bus.mem_alu_result}, 32'h8000);
    drive(1'b1, OP_XOR, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("xor_flags", {29'd0, flags}, 32'h5);
    drive(1'b1, OP_SLL, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("sll_flags", {29'd0, flags}, 32'h7);

    // 3: Z set, RED/PADDSB leave flags alone
    drive(1'b1, OP_ADD, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("set_z", {29'd0, flags}, 32'h2);
    drive(1'b1, OP_RED, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("red_flags", {29'd0, flags}, 32'h2);
    check("red_alu", {16'd0, bus.mem_alu_result}, 32'h0000);
    check("red_rw", {31'd0, bus.mem_reg_write}, 32'd1);
    drive(1'b1, OP_PADDSB, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("padd_flags", {29'd0, flags}, 32'h2);

    // 4: stall 3 cycles on ADD 0x1234, then release
    drive(1'b1, OP_ADD, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_alu%0d", i), {16'd0, bus.mem_alu_result}, 32'h8001);
      check($sformatf("stall_flags%0d", i), {29'd0, flags}, 32'h2);
    end
    stall = 1'b0;
    step();
    check("rel_alu", {16'd0, bus.mem_alu_result}, 32'h1234);
    check("rel_flags", {29'd0, flags}, 32'h0);

    // 5: SW with flush and stall together -> bubble
    drive(1'b1, 4'b1001, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    flush = 1'b1; stall = 1'b1;
    step();
    check("fl_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("fl_mw", {31'd0, bus.mem_mem_write}, 32'd0);
    check("fl_rw", {31'd0, bus.mem_reg_write}, 32'd0);
    check("fl_flags", {29'd0, flags}, 32'h0);
    // flush of an ADD must not touch flags or data
    stall = 1'b0;
    drive(1'b1, OP_ADD, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("fl_add_flags", {29'd0, flags}, 32'h0);
    check("fl_add_alu", {16'd0, bus.mem_alu_result}, 32'h1234);
    flush = 1'b0;

    // bubble advance: data copied, flags hold
    drive(1'b0, OP_ADD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("bub_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("bub_alu", {16'd0, bus.mem_alu_result}, 32'h0);
    check("bub_flags", {29'd0, flags}, 32'h0);

    // 6: LW then reset mid-stream with halt
    drive(1'b1, OP_ADD, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("pre_flags", {29'd0, flags}, 32'h4);
    check("pre_mr", {31'd0, bus.mem_mem_read}, 32'd1);
    drive(1'b1, 4'b1111, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1; stall = 1'b1;
    step();
    check("r6_halt", {31'd0, bus.mem_halt}, 32'd0);
    check("r6_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("r6_alu", {16'd0, bus.mem_alu_result}, 32'd0);
    check("r6_mr", {31'd0, bus.mem_mem_read}, 32'd0);
    check("r6_flags", {29'd0, flags}, 32'd0);
    rst = 1'b0; stall = 1'b0;
    step();
    check("post_halt", {31'd0, bus.mem_halt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
